// File: rtl/alu_chain_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_chain_pkg
// Brief    : Shared types and constants for the chained byte-serial adder.
// Revision : 1.0 - initial release
// ============================================================================
package alu_chain_pkg;

    localparam int   SLICE_W = 8;

    localparam logic OP_ADD  = 1'b0;
    localparam logic OP_SUB  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : alu_chain_pkg
`default_nettype wire

// File: rtl/alu_slice_8.sv
`default_nettype none
// ============================================================================
// Module   : alu_slice_8
// Brief    : Combinational 8-bit full-adder slice with carry in and out.
// Revision : 1.0 - initial release
// ============================================================================
module alu_slice_8
    import alu_chain_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    // Widen by one bit so the carry-out falls out of the sum directly.
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, ci};

endmodule : alu_slice_8
`default_nettype wire

// File: rtl/alu_chain_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_chain_seq
// Brief    : Byte-serial WORDS*8-bit add/subtract unit. One 8-bit slice is
//            reused per cycle, LSB byte first, carry chained through a
//            register. Registers result plus C/OF/ZF/NF flags.
//            Optional macro ALU_CHAIN_SAT_EN enables signed saturation of S
//            on overflow.
// Revision : 1.0 - initial release
// ============================================================================
module alu_chain_seq
    import alu_chain_pkg::*;
#(
    parameter int WORDS = 2
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       op_sub,
    input  logic                       Cin,
    input  logic [SLICE_W*WORDS-1:0]   X,
    input  logic [SLICE_W*WORDS-1:0]   Y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*WORDS-1:0]   S,
    output logic                       C,
    output logic                       OF,
    output logic                       ZF,
    output logic                       NF
);

    localparam int             W      = SLICE_W * WORDS;
    localparam int             K_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [K_W-1:0] LAST_K = K_W'(WORDS - 1);

    state_t                r_state;
    state_t                w_state_next;

    logic [W-1:0]          r_x;
    logic [W-1:0]          r_y;        // Y already inverted for subtract
    logic                  r_carry;
    logic [K_W-1:0]        r_k;
    logic                  r_zacc;
    logic [W-1:0]          r_s;
    logic                  r_c;
    logic                  r_of;
    logic                  r_zf;
    logic                  r_nf;

    logic [K_W+2:0]        w_base;
    logic [SLICE_W-1:0]    w_slice_a;
    logic [SLICE_W-1:0]    w_slice_b;
    logic [SLICE_W-1:0]    w_slice_s;
    logic                  w_slice_co;
    logic                  w_last;
    logic                  w_of;
    logic [W-1:0]          w_s_ins;
    logic [W-1:0]          w_s_final;
    logic                  w_zf_final;
    logic                  w_nf_final;

    // Bit offset of the slice currently being processed.
    assign w_base    = {r_k, 3'b000};
    assign w_slice_a = r_x[w_base +: SLICE_W];
    assign w_slice_b = r_y[w_base +: SLICE_W];
    assign w_last    = (r_k == LAST_K);

    alu_slice_8 u_slice (
        .a  (w_slice_a),
        .b  (w_slice_b),
        .ci (r_carry),
        .s  (w_slice_s),
        .co (w_slice_co)
    );

    // Signed overflow: operands agree in sign but the top byte's sign differs.
    assign w_of = (r_x[W-1] == r_y[W-1]) && (w_slice_s[SLICE_W-1] != r_x[W-1]);

    // Merge the fresh slice result into the running result word.
    always_comb begin
        w_s_ins                      = r_s;
        w_s_ins[w_base +: SLICE_W]   = w_slice_s;
    end

`ifdef ALU_CHAIN_SAT_EN
    // Clamp to the most positive / most negative value on overflow.
    always_comb begin
        w_s_final  = w_of ? {r_x[W-1], {(W-1){~r_x[W-1]}}} : w_s_ins;
        w_zf_final = (w_s_final == '0);
        w_nf_final = w_s_final[W-1];
    end
`else
    // Plain modulo result; zero flag uses the running zero accumulator.
    always_comb begin
        w_s_final  = w_s_ins;
        w_zf_final = r_zacc & (w_slice_s == 8'h00);
        w_nf_final = w_slice_s[SLICE_W-1];
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_next = CALC;
            end
            CALC: begin
                if (w_last) w_state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, per-slice accumulation and flag registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x     <= '0;
            r_y     <= '0;
            r_carry <= 1'b0;
            r_k     <= '0;
            r_zacc  <= 1'b0;
            r_s     <= '0;
            r_c     <= 1'b0;
            r_of    <= 1'b0;
            r_zf    <= 1'b0;
            r_nf    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x     <= X;
                        r_y     <= (op_sub == OP_ADD) ? Y : ~Y;
                        r_carry <= (op_sub == OP_ADD) ? Cin : 1'b1;
                        r_k     <= '0;
                        r_zacc  <= 1'b1;
                    end
                end
                CALC: begin
                    r_s     <= w_last ? w_s_final : w_s_ins;
                    r_carry <= w_slice_co;
                    r_zacc  <= r_zacc & (w_slice_s == 8'h00);
                    r_k     <= r_k + 1'b1;
                    if (w_last) begin
                        r_c  <= w_slice_co;
                        r_of <= w_of;
                        r_zf <= w_zf_final;
                        r_nf <= w_nf_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign S  = r_s;
    assign C  = r_c;
    assign OF = r_of;
    assign ZF = r_zf;
    assign NF = r_nf;

endmodule : alu_chain_seq
`default_nettype wire

// File: tb/tb_alu_chain_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_chain_seq
// Brief    : Self-checking bench for alu_chain_seq (directed + random ops
//            against an arithmetic reference model). Honours ALU_CHAIN_SAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_chain_seq;

    localparam int WORDS = 2;
    localparam int W     = 8 * WORDS;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic          op_sub;
    logic          Cin;
    logic [W-1:0]  X;
    logic [W-1:0]  Y;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  S;
    logic          C;
    logic          OF;
    logic          ZF;
    logic          NF;

    int n_checks = 0;
    int n_errors = 0;

    alu_chain_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .Cin       (Cin),
        .X         (X),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .C         (C),
        .OF        (OF),
        .ZF        (ZF),
        .NF        (NF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: integer arithmetic on unsigned and signed interpretations.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic sub, input logic cin,
                                  output logic [W-1:0] s, output logic c,
                                  output logic of, output logic zf, output logic nf);
        longint sx, sy, sr, smax, smin;
        logic [W:0] usum;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        smax = (longint'(1) <<< (W - 1)) - 1;
        smin = -(longint'(1) <<< (W - 1));
        if (sub) begin
            s  = W'(x - y);
            c  = (x >= y);
            sr = sx - sy;
        end else begin
            usum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
            s    = usum[W-1:0];
            c    = usum[W];
            sr   = sx + sy + longint'(cin);
        end
        of = (sr > smax) || (sr < smin);
`ifdef ALU_CHAIN_SAT_EN
        if (of) s = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        zf = (s == '0);
        nf = s[W-1];
    endfunction

    // Issue one operation, check latency/result, hold in DONE for `hold`
    // cycles while throwing junk at the input side, then release it.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic sub, input logic cin, input int hold);
        logic [W-1:0] es;
        logic         ec, eof, ezf, enf;
        int           lat;
        model(x, y, sub, cin, es, ec, eof, ezf, enf);
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; X = x; Y = y; op_sub = sub; Cin = cin;
        @(posedge clk); #1;
        in_valid = 1'b0;
        X = W'({$urandom, $urandom}); Y = W'({$urandom, $urandom});
        op_sub = 1'($urandom); Cin = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 4 * WORDS + 4) begin
            chk("in_ready_busy", in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, WORDS);
        chk("S", S, es);
        chk("C", C, ec);
        chk("OF", OF, eof);
        chk("ZF", ZF, ezf);
        chk("NF", NF, enf);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            X = W'({$urandom, $urandom}); Y = W'({$urandom, $urandom});
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready, 0);
            chk("hold_S", S, es);
            chk("hold_flags", {C, OF, ZF, NF}, {ec, eof, ezf, enf});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_ready", in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_sub = 1'b0; Cin = 1'b0; X = '0; Y = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_S", S, 0);
        chk("rst_flags", {C, OF, ZF, NF}, 4'b0000);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;

        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b1, 1'b0, 0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h0000, 16'h0000, 1'b0, 1'b1, 0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        run_op(16'h1234, 16'h1234, 1'b1, 1'b1, 1);

        // Stall in DONE with junk on the input; nothing must be accepted.
        run_op(16'hA5C3, 16'h1E0F, 1'b0, 1'b1, 5);
        for (int i = 0; i < WORDS + 2; i++) begin
            @(posedge clk); #1;
            chk("no_stray_op", out_valid, 0);
            chk("no_stray_ready", in_ready, 1);
        end

        // Reset mid-calculation after the first slice.
        run_op(16'hF0F0, 16'h0F01, 1'b0, 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b1; X = 16'h5555; Y = 16'h2222; op_sub = 1'b0; Cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_S", S, 0);
        chk("midrst_flags", {C, OF, ZF, NF}, 4'b0000);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);
        chk("post_rst_sum", S, 16'h2345);

        for (int i = 0; i < 40; i++)
            run_op(W'({$urandom, $urandom}), W'({$urandom, $urandom}),
                   1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_alu_chain_seq
`default_nettype wire

// File: doc/alu_chain_seq.md
Name: alu_chain_seq

Overview:
- Sequential multi-byte add/subtract unit built around the team's 8-bit adder slice.
- Processes a WORDS×8-bit operand pair one byte per cycle, least-significant byte first, chaining carry between slices.
- Registers the full result plus C/OF/ZF/NF flags.
- Sits directly downstream of the operand source and upstream of the flag/result consumer, using valid/ready handshakes on both sides.

Parameters:
- WORDS, 2: number of 8-bit slices. Datapath width W = 8*WORDS. Legal range 1..8.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair presented.
- in_ready  out  1  unit idle and able to accept.
- op_sub  in  1  0: X+Y+Cin; 1: X+~Y+1 (Cin ignored).
- Cin  in  1  carry-in for add.
- X  in  W  operand A.
- Y  in  W  operand B.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- S  out  W  result.
- C  out  1  final carry-out. For sub, 1 means no borrow.
- OF  out  1  signed overflow.
- ZF  out  1  S == 0.
- NF  out  1  S[W-1].

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - S=0, C=0, OF=0, ZF=0, NF=0, out_valid=0, in_ready=1.
  - Slice index and carry register clear.
  - Applies immediately, including mid-CALC or in DONE; any in-flight operation is discarded.
- FSM has three states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch X, Y_eff (Y or ~Y) and c0 (Cin, or 1 for sub).
  - Then clear k=0 and set zacc=1, and go to CALC.
- CALC:
  - in_ready=0.
  - Each edge computes {c,s} = X[k] + Y_eff[k] + carry on slice k.
  - Writes s into S[8k+7:8k], updates carry, zacc &= (s==0), and sets k++.
  - On the edge with k==WORDS-1:
    - C = final carry.
    - OF = (X[W-1]==Y_eff[W-1]) && (s[7]!=X[W-1]).
    - ZF = zacc & (s==0).
    - NF = s[7].
    - Go to DONE.
- DONE:
  - out_valid=1.
  - S and flags held stable while out_ready=0.
  - Edge with out_ready=1: clear out_valid and go to IDLE. There is no same-cycle accept of the next operand.
- Latency: out_valid rises exactly WORDS edges after the accepting edge. Minimum initiation interval is WORDS+2 cycles.
- in_valid while in CALC/DONE is ignored; operands are not sampled.
- S shows partial results during CALC; consumers use S only when out_valid=1.
- Wrap-around: with the feature off, S is W-bit modulo and the carry is exported only via C.
- WORDS=1 degenerates to single-cycle CALC: k starts at last slice.

Optional Feature:
- Macro: ALU_CHAIN_SAT_EN.
- Defined: on the final CALC edge, if OF=1, S is forced to 0x7F..F when X[W-1]=0, or 0x80..0 when X[W-1]=1. OF still reports 1, and ZF/NF are computed from the saturated S.
- Undefined: S wraps; no saturation logic is present.

Decomposition:
- Package alu_chain_pkg:
  - SLICE_W=8.
  - State enum {IDLE, CALC, DONE}.
  - OP_ADD=1'b0, OP_SUB=1'b1.
- Sub-module alu_slice_8: combinational 8-bit adder, inputs a[7:0], b[7:0], ci; outputs s[7:0], co. The top instantiates it once and time-multiplexes it over slices.

Test Plan:
1. WORDS=2, add X=0x00FF Y=0x0001 Cin=0 -> S=0x0100, C=0, OF=0, ZF=0, NF=0; out_valid exactly 2 edges after accept.
2. Sub X=0x8000 Y=0x0001 -> S=0x7FFF, C=1, OF=1, ZF=0, NF=0.
3. Add X=0xFFFF Y=0x0001 Cin=0 -> S=0x0000, C=1, ZF=1, OF=0; add X=0x0000 Y=0x0000 Cin=1 -> S=0x0001, ZF=0.
4. Hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new operands -> S/flags unchanged, in_ready=0, second operand never taken; release out_ready -> in_ready=1 one cycle later.
5. Assert rst_n=0 during CALC after slice 0 -> S=0, flags=0, out_valid=0 immediately; after release, in_ready=1 and a fresh add 0x1234+0x1111 gives S=0x2345.
6. Add X=0x7FFF Y=0x0001: macro off -> S=0x8000, OF=1, NF=1; ALU_CHAIN_SAT_EN on -> S=0x7FFF, OF=1, NF=0.
